// File: rtl/ram_pkg.sv
// Shared definitions for the RAM read-modify-write controller.
//   RAM_DEPTH_DEFAULT : default RAM depth in 32-bit words
//   size_t / SZ_*     : request size encodings
//   state_e           : controller FSM states
package ram_pkg;

  localparam int unsigned RAM_DEPTH_DEFAULT = 4096;
  localparam int unsigned XLEN              = 32;

  typedef logic [1:0] size_t;

  localparam size_t SZ_BYTE    = 2'b00;
  localparam size_t SZ_HALF    = 2'b01;
  localparam size_t SZ_WORD    = 2'b10;
  localparam size_t SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/ram_lane_merge.sv
// Combinational byte/half/word lane handling for sub-word RAM access.
//   old_word  : word read from RAM
//   wdata     : right-justified store data
//   size      : access size (SZ_*)
//   byte_off  : addr[1:0] of the access
//   zero_ext  : 1 = zero-extend loads, 0 = sign-extend
//   new_word  : old_word with the addressed lane replaced by wdata
//   rdata     : addressed lane shifted to bit 0 and extended
module ram_lane_merge
  import ram_pkg::*;
(
  input  logic [XLEN-1:0] old_word,
  input  logic [XLEN-1:0] wdata,
  input  size_t           size,
  input  logic [1:0]      byte_off,
  input  logic            zero_ext,
  output logic [XLEN-1:0] new_word,
  output logic [XLEN-1:0] rdata
);

  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Bit offset of the addressed lane; half lanes ignore addr[0].
  assign byte_shift = {byte_off, 3'b000};
  assign half_shift = {byte_off[1], 4'b0000};
  assign lane_b     = old_word[byte_shift +: 8];
  assign lane_h     = old_word[half_shift +: 16];

  // Merge: replace only the addressed bits.
  always_comb begin
    new_word = old_word;
    case (size)
      SZ_BYTE: new_word[byte_shift +: 8]  = wdata[7:0];
      SZ_HALF: new_word[half_shift +: 16] = wdata[15:0];
      SZ_WORD: new_word                   = wdata;
      default: new_word                   = old_word;
    endcase
  end

  // Extract: lane to bit 0, then extend.
  always_comb begin
    rdata = '0;
    case (size)
      SZ_BYTE: rdata = zero_ext ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: rdata = zero_ext ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      SZ_WORD: rdata = old_word;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/ram_rmw_ctrl.sv
// Request-side controller for a 32-bit word RAM without byte enables.
// Loads read and extract a lane; sub-word stores read-modify-write;
// word stores write directly. One response per request with an error flag.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid_i/req_ready_o  : request handshake (ready only in IDLE)
//   req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i : request
//   rsp_valid_o/rsp_ready_i  : response handshake
//   rsp_rdata_o, rsp_err_o   : response payload
//   ram_we_o, ram_addr_o, ram_wdata_o, ram_rdata_i : RAM port
module ram_rmw_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH = RAM_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            ram_we_o,
  output logic [XLEN-1:0] ram_addr_o,
  output logic [XLEN-1:0] ram_wdata_o,
  input  logic [XLEN-1:0] ram_rdata_i
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  size_t           size_q, size_d;
  logic            we_q, we_d;
  logic            uns_q, uns_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            ram_we_q, ram_we_d;
  logic [XLEN-1:0] ram_wdata_q, ram_wdata_d;
  logic            req_err;
  logic [XLEN-1:0] merged_word;
  logic [XLEN-1:0] load_data;

  ram_lane_merge u_lane (
    .old_word (ram_rdata_i),
    .wdata    (wdata_q),
    .size     (size_q),
    .byte_off (addr_q[1:0]),
    .zero_ext (uns_q),
    .new_word (merged_word),
    .rdata    (load_data)
  );

  // Alignment, size and range check on the incoming request.
  always_comb begin
    req_err = 1'b0;
    case (req_size_i)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr_i[0];
      SZ_WORD: req_err = |req_addr_i[1:0];
      default: req_err = 1'b1;
    endcase
    if (req_addr_i[31:2] >= 30'(DEPTH)) req_err = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= SZ_BYTE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    we_d        = we_q;
    uns_d       = uns_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          size_d  = req_size_i;
          we_d    = req_we_i;
          uns_d   = req_unsigned_i;
          if (req_err) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = ST_RESP;
          end else if (req_we_i && (req_size_i == SZ_WORD)) begin
            // Full-word store needs no read; write next cycle.
            ram_we_d    = 1'b1;
            ram_wdata_d = req_wdata_i;
            state_d     = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end

      ST_READ: begin
        if (we_q) begin
          ram_we_d    = 1'b1;
          ram_wdata_d = merged_word;
          state_d     = ST_WRITE;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
          rsp_err_d   = 1'b0;
          state_d     = ST_RESP;
        end
      end

      ST_WRITE: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  // Gate with rst so a write in the reset cycle never reaches the RAM.
  assign ram_we_o    = ram_we_q & ~rst;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = ram_wdata_q;

endmodule

// File: tb/tb_ram_rmw_ctrl.sv
// Self-checking bench for ram_rmw_ctrl: directed and random requests
// against a byte-array memory model, plus an attached RAM model.
module tb_ram_rmw_ctrl;

  localparam int unsigned DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  int tests = 0;
  int fails = 0;
  int we_count = 0;

  logic [31:0] mem [DEPTH];
  logic [7:0]  ref_b [DEPTH*4];
  logic        mem_loaded = 1'b0;

  always #5 clk = ~clk;

  ram_rmw_ctrl #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .ram_we_o       (ram_we),
    .ram_addr_o     (ram_addr),
    .ram_wdata_o    (ram_wdata),
    .ram_rdata_i    (ram_rdata)
  );

  function automatic logic [31:0] pat(int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  // RAM model: combinational read, write on clock edge.
  assign ram_rdata = (ram_addr[31:2] < 30'(DEPTH)) ? mem[ram_addr[13:2]] : 32'h0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= pat(i);
      mem_loaded <= 1'b1;
    end else if (ram_we) begin
      we_count <= we_count + 1;
      if (ram_addr[31:2] < 30'(DEPTH)) mem[ram_addr[13:2]] <= ram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
           || ((a >> 2) >= DEPTH);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] a,
                                           input logic uns);
    int n = 1 << sz;
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_b[int'(a) + i]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n = 1 << sz;
    for (int i = 0; i < n; i++) ref_b[int'(a) + i] = 8'(wd >> (8 * i));
  endtask

  // Issue one request starting at a negedge; returns at the negedge after the handshake.
  task automatic issue(input string tag, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd,
                       input int hold);
    logic        e_err;
    logic [31:0] e_dat, d0;
    logic        e0;
    int          e_lat, k, w0;
    bit          busy_ok, stable;
    e_err = exp_err(sz, a);
    e_dat = (we || e_err) ? 32'h0 : ref_load(sz, a, uns);
    e_lat = e_err ? 1 : ((we && sz != 2'd2) ? 3 : 2);
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    chk({tag, ":ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    w0 = we_count;
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    busy_ok = 1'b1;
    while (!rsp_valid && k < 10) begin
      busy_ok = busy_ok && !req_ready;
      @(negedge clk);
      k++;
    end
    busy_ok = busy_ok && !req_ready;
    chk({tag, ":latency"}, 32'(k), 32'(e_lat));
    chk({tag, ":rdata"}, rsp_rdata, e_dat);
    chk({tag, ":err"}, 32'(rsp_err), 32'(e_err));
    chk({tag, ":busy_not_ready"}, 32'(busy_ok), 32'd1);
    d0 = rsp_rdata; e0 = rsp_err; stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      stable = stable && (rsp_valid === 1'b1) && (rsp_rdata === d0) && (rsp_err === e0)
               && (req_ready === 1'b0);
    end
    if (hold > 0) chk({tag, ":hold_stable"}, 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ":post_hs"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    chk({tag, ":we_pulses"}, 32'(we_count - w0), (we && !e_err) ? 32'd1 : 32'd0);
    if (we && !e_err) ref_store(sz, a, wd);
  endtask

  initial begin
    int w0;
    logic [1:0]  sz;
    logic [31:0] a;
    int r;

    for (int i = 0; i < int'(DEPTH); i++) begin
      for (int b = 0; b < 4; b++) ref_b[i*4 + b] = 8'(pat(i) >> (8 * b));
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset:rsp_rdata", rsp_rdata, 32'd0);
    chk("reset:rsp_err", 32'(rsp_err), 32'd0);
    chk("reset:ram_we", 32'(ram_we), 32'd0);
    chk("reset:ram_addr", ram_addr, 32'd0);
    chk("reset:ram_wdata", ram_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1. word store then word load
    issue("t1_sw",  1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 0);
    issue("t1_lw",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    chk("t1_model", ref_load(2'd2, 32'h10, 1'b0), 32'h11223344);
    // 2. byte store, word/byte loads
    issue("t2_sb",  1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFFAB, 0);
    issue("t2_lw",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    issue("t2_lb",  1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0);
    issue("t2_lbu", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0);
    chk("t2_model", ref_load(2'd0, 32'h11, 1'b0), 32'hFFFFFFAB);
    // 3. half store, misaligned half load
    issue("t3_sh",  1'b1, 2'd1, 1'b0, 32'h12, 32'h00005566, 0);
    issue("t3_lw",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    chk("t3_model", ref_load(2'd2, 32'h10, 1'b0), 32'h5566AB44);
    issue("t3_lh_mis", 1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 0);
    // 4. out of range and illegal size
    issue("t4_oor", 1'b1, 2'd2, 1'b0, 32'h4000, 32'hDEADBEEF, 0);
    issue("t4_sz3", 1'b1, 2'd3, 1'b0, 32'h0, 32'hDEADBEEF, 0);
    issue("t4_lw0", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0);
    // 5. response back-pressure, then back-to-back accept
    issue("t5_lh",  1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 5);
    issue("t5_next", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 5);

    // Random mix against the byte model.
    for (int t = 0; t < 40; t++) begin
      sz = 2'($urandom_range(0, 3));
      r  = int'($urandom_range(0, 9));
      a  = (r == 0) ? 32'h4000 + 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 127));
      if (r >= 1 && r <= 6 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      issue($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            a, $urandom, int'($urandom_range(0, 2)));
    end

    // 6. reset during the WRITE cycle of a byte store
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h000000CD;
    chk("t6:ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("t6:we_in_write", 32'(ram_we), 32'd1);
    w0 = we_count;
    rst = 1'b1;
    #1;
    chk("t6:we_gated", 32'(ram_we), 32'd0);
    @(negedge clk);
    chk("t6:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6:rsp_rdata", rsp_rdata, 32'd0);
    chk("t6:rsp_err", 32'(rsp_err), 32'd0);
    chk("t6:ram_we", 32'(ram_we), 32'd0);
    chk("t6:ram_addr", ram_addr, 32'd0);
    chk("t6:ram_wdata", ram_wdata, 32'd0);
    chk("t6:no_write", 32'(we_count - w0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    issue("t6_lw", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);

    // Memory contents written by the DUT must match the model.
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("mem[%0d]", i), mem[i], ref_load(2'd2, 32'(i * 4), 1'b0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
